fcpu_rob: RTL and testbench
===========================

FCPU_ROB -- requirements
Module: fcpu_rob

Interface
REQ-001 The block SHALL have parameter N_ROB_W, default 4, meaning log2 of the entry count (16 entries).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the result width.
REQ-003 The block SHALL have parameter REG_ADDR_W, default 5, meaning the destination register address width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-006 The block SHALL have port alloc_valid  input  1  meaning dispatch requests an entry.
REQ-007 The block SHALL have port alloc_ready  output  1  meaning an entry is free.
REQ-008 The block SHALL have port alloc_dst_reg  input  REG_ADDR_W  meaning the destination register.
REQ-009 The block SHALL have port alloc_type  input  3  meaning the commit_type_t encoding.
REQ-010 The block SHALL have port alloc_tag  output  N_ROB_W  meaning the index of the entry allocated this cycle.
REQ-011 The block SHALL have port cdb_valid  input  1  meaning a result broadcast is present.
REQ-012 The block SHALL have port cdb_tag  input  N_ROB_W  meaning the destination entry of the result.
REQ-013 The block SHALL have port cdb_data  input  DATA_W  meaning the result value.
REQ-014 The block SHALL have port commit_valid  output  1  meaning the head entry is ready to retire.
REQ-015 The block SHALL have port commit_ready  input  1  meaning the register file or store unit accepts the commit.
REQ-016 The block SHALL have ports commit_dst_reg (REG_ADDR_W), commit_type (3), commit_data (DATA_W) and commit_tag (N_ROB_W), all outputs, carrying the head entry fields.
REQ-017 The block SHALL have port flush  input  1  meaning a misprediction squash.
REQ-018 The block SHALL have port count  output  N_ROB_W+1  meaning the number of occupied entries.

Function
REQ-019 Each entry SHALL hold valid, done, dst_reg, type and data; head and tail pointers SHALL be N_ROB_W+1 bits, wrapping modulo 2^(N_ROB_W+1).
REQ-020 alloc_ready SHALL equal (count != 2^N_ROB_W); it SHALL NOT depend on a same-cycle commit.
REQ-021 alloc_tag SHALL equal tail[N_ROB_W-1:0] combinationally.
REQ-022 An allocation SHALL occur when alloc_valid and alloc_ready: the entry is written with valid=1, done=0 and the alloc fields, and tail increments.
REQ-023 A CDB write SHALL set done=1 and data=cdb_data at entry cdb_tag only if that entry is valid and not done; otherwise the write is ignored.
REQ-024 commit_valid SHALL be (head entry valid and done) and not flush.
REQ-025 A commit SHALL occur when commit_valid and commit_ready: the head entry is cleared to valid=0 and head increments.
REQ-026 commit_valid SHALL stay asserted with stable fields until the commit is accepted.
REQ-027 count SHALL update as +1 on allocation, -1 on commit, unchanged when both occur in the same cycle.
REQ-028 An allocation and a commit SHALL both be able to complete in one cycle, including when tail wraps from index 15 to 0.
REQ-029 A CDB write to the entry being allocated in the same cycle SHALL be ignored.
REQ-030 When flush is high, allocation and CDB writes SHALL be ignored that cycle, and on the next edge all valid bits, head, tail and count SHALL become 0.

Reset
REQ-031 While rst is high, all entries SHALL be invalid; head, tail and count SHALL be 0; commit_valid SHALL be 0; alloc_ready SHALL be 1; alloc_tag SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries immediately, without waiting for a clock edge.

Configuration
REQ-033 With macro FCPU_ROB_BYPASS_EN defined, a valid CDB write to the head entry SHALL assert commit_valid in the same cycle, with commit_data=cdb_data.
REQ-034 With FCPU_ROB_BYPASS_EN undefined, commit_valid SHALL assert no earlier than the cycle after the CDB write to the head entry.

Verification
REQ-035 Allocate 16 entries with dst 1..16 -> tags 0..15, then alloc_ready=0 and count=16; a 17th alloc_valid is ignored.
REQ-036 Write results to tags 2, 1, 0 with data 0x30, 0x20, 0x10, commit_ready=1 -> commits occur in order tag 0, 1, 2 with data 0x10, 0x20, 0x30.
REQ-037 Full ROB, head done, with alloc_valid and commit_ready both high -> the commit occurs; the allocation waits one cycle, then receives tag 0.
REQ-038 Five entries in flight, flush pulsed together with cdb_valid to tag 3 -> next cycle count=0, alloc_tag=0 and commit_valid=0.
REQ-039 Write head tag 0 with data 0xDEADBEEF -> commit_valid is high in the same cycle when FCPU_ROB_BYPASS_EN is defined, and one cycle later when it is undefined.
REQ-040 Assert rst asynchronously while 4 entries are in flight with commit_ready=0 -> outputs immediately match REQ-031.

Source files
------------

// File: rtl/fcpu_rob.sv
// fcpu_rob: 2^N_ROB_W-entry reorder buffer with in-order commit and CDB writeback.
// Optional macro FCPU_ROB_BYPASS_EN lets a CDB write to the head entry commit in the same cycle.
module fcpu_rob #(
   parameter int N_ROB_W    = 4,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   input  logic [REG_ADDR_W-1:0] alloc_dst_reg,
   input  logic [2:0]            alloc_type,
   output logic [N_ROB_W-1:0]    alloc_tag,
   input  logic                  cdb_valid,
   input  logic [N_ROB_W-1:0]    cdb_tag,
   input  logic [DATA_W-1:0]     cdb_data,
   output logic                  commit_valid,
   input  logic                  commit_ready,
   output logic [REG_ADDR_W-1:0] commit_dst_reg,
   output logic [2:0]            commit_type,
   output logic [DATA_W-1:0]     commit_data,
   output logic [N_ROB_W-1:0]    commit_tag,
   input  logic                  flush,
   output logic [N_ROB_W:0]      count
);

   localparam int DEPTH = 1 << N_ROB_W;
   localparam logic [N_ROB_W:0] FULL_CNT = (N_ROB_W+1)'(DEPTH);

   logic [N_ROB_W:0]      head_reg, tail_reg;
   logic [DEPTH-1:0]      valid_reg, done_reg;
   logic [REG_ADDR_W-1:0] dst_mem  [DEPTH];
   logic [2:0]            type_mem [DEPTH];
   logic [DATA_W-1:0]     data_mem [DEPTH];

   logic [N_ROB_W-1:0] head_idx, tail_idx;
   logic               alloc_fire, cdb_hit, commit_fire, head_ready;

   assign head_idx    = head_reg[N_ROB_W-1:0];
   assign tail_idx    = tail_reg[N_ROB_W-1:0];
   // Pointers carry one extra wrap bit, so the difference is the occupancy directly.
   assign count       = tail_reg - head_reg;
   assign alloc_ready = (count != FULL_CNT);
   assign alloc_tag   = tail_idx;
   assign alloc_fire  = alloc_valid && alloc_ready && !flush;

   // A result only lands on a live, still-pending entry that is not being reallocated now.
   assign cdb_hit = cdb_valid && !flush && valid_reg[cdb_tag] && !done_reg[cdb_tag]
                    && !(alloc_fire && (cdb_tag == tail_idx));

`ifdef FCPU_ROB_BYPASS_EN
   assign head_ready  = done_reg[head_idx] || (cdb_hit && (cdb_tag == head_idx));
   assign commit_data = done_reg[head_idx] ? data_mem[head_idx] : cdb_data;
`else
   assign head_ready  = done_reg[head_idx];
   assign commit_data = data_mem[head_idx];
`endif

   assign commit_valid   = valid_reg[head_idx] && head_ready && !flush;
   assign commit_fire    = commit_valid && commit_ready;
   assign commit_dst_reg = dst_mem[head_idx];
   assign commit_type    = type_mem[head_idx];
   assign commit_tag     = head_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         valid_reg <= '0;
         done_reg  <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         valid_reg <= '0;
         done_reg  <= '0;
      end else begin
         if (cdb_hit)
            done_reg[cdb_tag] <= 1'b1;
         // Retiring the head frees the slot; a later allocation write to it wins if both hit.
         if (commit_fire) begin
            valid_reg[head_idx] <= 1'b0;
            done_reg[head_idx]  <= 1'b0;
            head_reg            <= head_reg + 1'b1;
         end
         if (alloc_fire) begin
            valid_reg[tail_idx] <= 1'b1;
            done_reg[tail_idx]  <= 1'b0;
            tail_reg            <= tail_reg + 1'b1;
         end
      end
   end

   // Payload needs no reset: it is only observed through a valid entry.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (alloc_fire && (tail_idx == N_ROB_W'(gi))) begin
            dst_mem[gi]  <= alloc_dst_reg;
            type_mem[gi] <= alloc_type;
         end
         if (cdb_hit && (cdb_tag == N_ROB_W'(gi)))
            data_mem[gi] <= cdb_data;
      end
   end

endmodule

// File: tb/tb_fcpu_rob.sv
// tb_fcpu_rob: directed stimulus for fcpu_rob; a monitor scoreboards every accepted commit.
module tb_fcpu_rob;

`ifdef FCPU_ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_valid = 1'b0, alloc_ready;
   logic [4:0]  alloc_dst_reg = '0;
   logic [2:0]  alloc_type = '0;
   logic [3:0]  alloc_tag;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        commit_valid, commit_ready = 1'b0;
   logic [4:0]  commit_dst_reg;
   logic [2:0]  commit_type;
   logic [31:0] commit_data;
   logic [3:0]  commit_tag;
   logic        flush = 1'b0;
   logic [4:0]  count;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dst;
      logic [2:0]  typ;
      logic [31:0] data;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int failures = 0;

   fcpu_rob dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_dst_reg(alloc_dst_reg), .alloc_type(alloc_type), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_dst_reg(commit_dst_reg), .commit_type(commit_type),
      .commit_data(commit_data), .commit_tag(commit_tag),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end else
         $display("ok   %s = 0x%0h", nm, act);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_count(input string nm, input logic [4:0] want);
      for (int i = 0; i < 20 && count !== want; i++) tick();
      chk(nm, 32'(count), 32'(want));
   endtask

   // Commit monitor: a commit is accepted at the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && commit_valid && commit_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_commit_tag", 32'(commit_tag), 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               chk("commit_tag", 32'(commit_tag), 32'(e.tag));
               chk("commit_dst", 32'(commit_dst_reg), 32'(e.dst));
               chk("commit_type", 32'(commit_type), 32'(e.typ));
               chk("commit_data", commit_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_alloc_ready", 32'(alloc_ready), 1);
      chk("rst_alloc_tag", 32'(alloc_tag), 0);
      chk("rst_commit_valid", 32'(commit_valid), 0);
      rst = 1'b0;
      tick();

      // Fill all 16 entries, dst 1..16, type i%8
      for (int i = 0; i < 16; i++) begin
         alloc_valid = 1'b1;
         alloc_dst_reg = 5'(i + 1);
         alloc_type = 3'(i % 8);
         #1;
         chk($sformatf("fill_tag%0d", i), 32'(alloc_tag), 32'(i));
         tick();
      end
      alloc_dst_reg = 5'd31;
      chk("full_alloc_ready", 32'(alloc_ready), 0);
      chk("full_count", 32'(count), 16);
      tick();
      chk("full_17th_ignored", 32'(count), 16);

      // Full ROB, head result arrives while alloc and commit are both requested
      commit_ready = 1'b1;
      alloc_dst_reg = 5'd17;
      alloc_type = 3'd5;
      cdb_valid = 1'b1;
      cdb_tag = 4'd0;
      cdb_data = 32'hDEADBEEF;
      sbq.push_back('{tag: 4'd0, dst: 5'd1, typ: 3'd0, data: 32'hDEADBEEF});
      #1;
      chk("bypass_same_cycle_cv", 32'(commit_valid), 32'(BYP));
      chk("full_no_alloc", 32'(alloc_ready), 0);
      tick();
      cdb_valid = 1'b0;
      chk("bypass_next_cycle_cv", 32'(commit_valid), 32'(!BYP));
      for (int i = 0; i < 5 && alloc_ready !== 1'b1; i++) tick();
      chk("wrap_alloc_ready", 32'(alloc_ready), 1);
      chk("wrap_alloc_tag", 32'(alloc_tag), 0);
      chk("wrap_count", 32'(count), 15);
      tick();
      alloc_valid = 1'b0;
      chk("wrap_refill_count", 32'(count), 16);

      // Out-of-order results, in-order commits
      sbq.push_back('{tag: 4'd1, dst: 5'd2, typ: 3'd1, data: 32'h10});
      sbq.push_back('{tag: 4'd2, dst: 5'd3, typ: 3'd2, data: 32'h20});
      sbq.push_back('{tag: 4'd3, dst: 5'd4, typ: 3'd3, data: 32'h30});
      cdb_valid = 1'b1;
      cdb_tag = 4'd3; cdb_data = 32'h30; tick();
      cdb_tag = 4'd2; cdb_data = 32'h20; tick();
      cdb_tag = 4'd1; cdb_data = 32'h10; tick();
      cdb_valid = 1'b0;
      wait_count("ooo_count", 5'd13);
      chk("ooo_alloc_tag", 32'(alloc_tag), 1);

      // Flush clears everything; then five entries and a flush coincident with a CDB write
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush1_count", 32'(count), 0);
      chk("flush1_alloc_tag", 32'(alloc_tag), 0);
      for (int i = 0; i < 5; i++) begin
         alloc_valid = 1'b1;
         alloc_dst_reg = 5'(i + 20);
         alloc_type = 3'(i);
         tick();
      end
      chk("five_count", 32'(count), 5);
      flush = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h99;
      #1;
      chk("flush_cv_low", 32'(commit_valid), 0);
      tick();
      flush = 1'b0; cdb_valid = 1'b0;
      alloc_dst_reg = 5'd7; alloc_type = 3'd6;
      chk("flush2_count", 32'(count), 0);
      chk("flush2_alloc_tag", 32'(alloc_tag), 0);
      chk("flush2_cv", 32'(commit_valid), 0);
      tick();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h99;
      tick();
      cdb_valid = 1'b0;
      tick();
      chk("stale_cdb_ignored_cv", 32'(commit_valid), 0);
      sbq.push_back('{tag: 4'd0, dst: 5'd7, typ: 3'd6, data: 32'h77});
      cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h77;
      tick();
      cdb_valid = 1'b0;
      wait_count("post_flush_drain", 5'd0);

      // Asynchronous reset with 4 entries in flight and the head ready
      commit_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1;
         alloc_dst_reg = 5'(i + 10);
         alloc_type = 3'(i);
         tick();
      end
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h5;
      tick();
      cdb_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 4);
      chk("pre_rst_cv", 32'(commit_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_alloc_ready", 32'(alloc_ready), 1);
      chk("async_rst_alloc_tag", 32'(alloc_tag), 0);
      chk("async_rst_cv", 32'(commit_valid), 0);
      #2;
      rst = 1'b0;
      tick();
      chk("post_rst_count", 32'(count), 0);
      chk("scoreboard_empty", 32'(sbq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
